// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: fetch-PC owner plus a small FIFO between the
// instruction memory and the IF/ID register. One fetch per cycle, in-order
// delivery of {instruction, PC+4}, and a redirect flush that keeps the
// delay-slot instruction being accepted by decode in the redirect cycle.
// Optional performance counters are built when PREFETCH_PERF_EN is defined.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       Clk,
  input  logic                       Rst,
  output logic [31:0]                IMemAddr,
  input  logic [31:0]                IMemData,
  input  logic                       IMemReady,
  input  logic                       Redirect,
  input  logic [31:0]                RedirectPC,
  input  logic                       OutReady,
  output logic                       OutValid,
  output logic [31:0]                OutInstruction,
  output logic [31:0]                OutPCAddResult,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic [31:0]                PerfFlushed,
  output logic [31:0]                PerfStarved
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc4   [DEPTH];

  logic        w_valid;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [31:0] w_redir_pc;

  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = w_valid & OutReady;
  // A full queue can still accept a fetch when the head leaves this cycle.
  assign w_push     = IMemReady & ~Redirect & (~w_full | w_pop);
  assign w_redir_pc = RedirectPC & 32'hFFFF_FFFC;

  assign IMemAddr       = r_fetch_pc;
  assign OutValid       = w_valid;
  assign Count          = r_count;
  // Head mux is driven only by registered state; empty presents zeros.
  assign OutInstruction = w_valid ? r_instr[r_rd_ptr] : 32'h0;
  assign OutPCAddResult = w_valid ? r_pc4[r_rd_ptr]   : 32'h0;

  // Control state: fetch PC, pointers and occupancy; redirect flushes after the head pop.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (Redirect) begin
      r_fetch_pc <= w_redir_pc;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_wr_ptr   <= r_wr_ptr + AW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage: no reset, written only on an accepted fetch.
  always_ff @(posedge Clk) begin
    if (Rst && w_push) begin
      r_instr[r_wr_ptr] <= IMemData;
      r_pc4[r_wr_ptr]   <= r_fetch_pc + 32'd4;
    end
  end

`ifdef PREFETCH_PERF_EN
  logic [31:0] r_flushed;
  logic [31:0] r_starved;
  logic [31:0] w_flush_n;
  logic [32:0] w_flush_sum;

  // Entries lost to a redirect: everything queued except a head that was just delivered.
  assign w_flush_n   = 32'(r_count) - (w_pop ? 32'd1 : 32'd0);
  assign w_flush_sum = {1'b0, r_flushed} + {1'b0, w_flush_n};

  // Saturating flush and starvation counters.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_flushed <= '0;
      r_starved <= '0;
    end else begin
      if (Redirect)
        r_flushed <= w_flush_sum[32] ? 32'hFFFF_FFFF : w_flush_sum[31:0];
      if (OutReady && !w_valid && (r_starved != 32'hFFFF_FFFF))
        r_starved <= r_starved + 32'd1;
    end
  end

  assign PerfFlushed = r_flushed;
  assign PerfStarved = r_starved;
`else
  assign PerfFlushed = 32'h0;
  assign PerfStarved = 32'h0;
`endif

endmodule
